dual_port_sync_ram: RTL and testbench

Parametrised simple-dual-port synchronous RAM: one write port and one read port on a shared clock, with byte-enable writes and configurable read latency 1 or 2. It adds a self-clearing initialisation sequencer after reset and write-first read/write collision forwarding. It replaces the single-port, tri-state-data RAM wherever a datapath must read and write in the same cycle.

---
 rtl/ram_pkg.sv | 35 +++
 rtl/ram_read_pipe.sv | 57 +++++
 rtl/dual_port_sync_ram.sv | 123 ++++++++++++
 tb/tb_dual_port_sync_ram.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types, constants and the byte-merge helper for dual_port_sync_ram.
//   ram_state_t : sequencer state (INIT clears the array, READY serves ports)
//   BYTE_W      : width of one byte-enable lane
//   MAX_DATA_W  : widest word be_merge can handle; callers zero-extend into it
//   be_merge()  : old word with every enabled byte replaced by the new byte
// ---------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic [0:0] {
        INIT,
        READY
    } ram_state_t;

    localparam int BYTE_W     = 8;
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

    // Works at a fixed maximum width so one function serves any DATA_WIDTH;
    // callers extend the operands and cast the result back down.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] r;
        r = old_w;
        for (int k = 0; k < MAX_BE_W; k++) begin
            if (be[k]) r[k*BYTE_W +: BYTE_W] = new_w[k*BYTE_W +: BYTE_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// ---------------------------------------------------------------------------
// ram_read_pipe
// LATENCY-deep register chain carrying {valid, data} from the array read to
// the read port. A data stage only loads when a valid word arrives, so the
// output word holds its last value across idle cycles.
//   clk, rst     : clock, synchronous active-high reset (clears valid bits)
//   in_valid_i   : read accepted this cycle
//   in_data_i    : word read (already collision-forwarded)
//   out_valid_o  : rd_valid
//   out_data_o   : rd_data
// ---------------------------------------------------------------------------
module ram_read_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic [LATENCY-1:0]                 vld_q;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] data_q;
    logic [LATENCY-1:0]                 vld_d;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] data_d;

    // Input of each stage: stage 0 takes the array read, later stages take
    // the previous stage.
    always_comb begin
        vld_d  = '0;
        data_d = '0;
        vld_d[0]  = in_valid_i;
        data_d[0] = in_data_i;
        for (int s = 1; s < LATENCY; s++) begin
            vld_d[s]  = vld_q[s-1];
            data_d[s] = data_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < LATENCY; s++) begin
            if (rst) vld_q[s] <= 1'b0;
            else     vld_q[s] <= vld_d[s];

            // Only the visible output word is zeroed on reset so rd_data
            // reads 0 afterwards; inner stages are masked by their valid bit.
            if (rst && (s == LATENCY - 1)) data_q[s] <= '0;
            else if (vld_d[s])             data_q[s] <= data_d[s];
        end
    end

    assign out_valid_o = vld_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/dual_port_sync_ram.sv
// ---------------------------------------------------------------------------
// dual_port_sync_ram
// Simple-dual-port synchronous RAM: one byte-enabled write port, one read
// port, shared clock. After reset a sequencer writes INIT_VALUE to every
// location (DEPTH cycles) while init_busy is high and both ports are ignored.
// A read and write to the same address in one cycle return the merged
// (write-first) word.
//   clk, rst            : clock, synchronous active-high reset
//   chip_select         : gates both ports
//   wr_en/addr/data/be  : write request, byte enables per 8-bit lane
//   rd_en/addr          : read request
//   rd_data, rd_valid   : read result READ_LATENCY cycles after request
//   init_busy           : clear sequence running
// ---------------------------------------------------------------------------
module dual_port_sync_ram
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chip_select,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [DATA_WIDTH/8-1:0]    wr_be,
    input  logic                       rd_en,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       init_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
        $error("dual_port_sync_ram: DATA_WIDTH must be a multiple of 8");
    end
    if (DATA_WIDTH > MAX_DATA_W) begin : g_too_wide
        $error("dual_port_sync_ram: DATA_WIDTH exceeds ram_pkg::MAX_DATA_W");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("dual_port_sync_ram: READ_LATENCY must be 1 or 2");
    end

    ram_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy;
    logic                  init_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_fire, rd_fire;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    // ---- sequencer: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---- sequencer: next state ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (&cnt_q) state_d = READY;
            end
            default: ;
        endcase
    end

    // ---- sequencer: outputs ----
    always_comb begin
        busy    = (state_q == INIT);
        init_we = (state_q == INIT) && !rst;
    end

    assign init_busy = busy;

    // Requests are dropped while clearing and in the reset cycle itself.
    assign wr_fire = chip_select && wr_en && !busy && !rst;
    assign rd_fire = chip_select && rd_en && !busy && !rst;

    assign wr_merged = DATA_WIDTH'(be_merge(MAX_DATA_W'(mem[wr_addr]),
                                            MAX_DATA_W'(wr_data),
                                            MAX_BE_W'(wr_be)));

    always_ff @(posedge clk) begin
        if (init_we)      mem[cnt_q]   <= INIT_VALUE;
        else if (wr_fire) mem[wr_addr] <= wr_merged;
    end

    // Write-first: a same-address write this cycle is forwarded into the
    // read, so the read sees exactly the word the array will hold.
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_fire && (wr_addr == rd_addr)) rd_word = wr_merged;
    end

    ram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_read_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_fire),
        .in_data_i   (rd_word),
        .out_valid_o (rd_valid),
        .out_data_o  (rd_data)
    );

endmodule

// File: tb/tb_dual_port_sync_ram.sv
module tb_dual_port_sync_ram;

    localparam int              AW    = 4;
    localparam int              DW    = 16;
    localparam int              BW    = DW / 8;
    localparam int              DEPTH = 16;
    localparam logic [DW-1:0]   INITV = 16'hA5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cs, we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;

    logic [DW-1:0] rdata1, rdata2;
    logic          rvalid1, rvalid2, busy1, busy2;

    dual_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .INIT_VALUE(INITV)) u_dut1 (
        .clk(clk), .rst(rst), .chip_select(cs), .wr_en(we), .wr_addr(wa), .wr_data(wd), .wr_be(be),
        .rd_en(re), .rd_addr(ra), .rd_data(rdata1), .rd_valid(rvalid1), .init_busy(busy1));

    dual_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .INIT_VALUE(INITV)) u_dut2 (
        .clk(clk), .rst(rst), .chip_select(cs), .wr_en(we), .wr_addr(wa), .wr_data(wd), .wr_be(be),
        .rd_en(re), .rd_addr(ra), .rd_data(rdata2), .rd_valid(rvalid2), .init_busy(busy2));

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb1[$];
    exp_t          sb2[$];
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] last1, last2;
    int            init_left;
    int            cyc;
    bit            started;
    int            n_tests, n_fail;

    // Reference byte-enable update: build a lane mask, then blend.
    function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                               input logic [BW-1:0] b);
        logic [DW-1:0] m;
        m = '0;
        for (int k = 0; k < BW; k++) if (b[k]) m = m | (DW'(16'h00FF) << (8 * k));
        return (o & ~m) | (n & m);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic port_chk(input int p, input logic v, input logic [DW-1:0] d);
        exp_t e;
        bit   have;
        if (p == 1) have = (sb1.size() > 0) && (sb1[0].due == cyc);
        else        have = (sb2.size() > 0) && (sb2[0].due == cyc);
        if (have) begin
            if (p == 1) e = sb1.pop_front();
            else        e = sb2.pop_front();
            chk($sformatf("rd_valid L%0d", p), DW'(v), DW'(1));
            chk($sformatf("rd_data L%0d", p), d, e.data);
            if (p == 1) last1 = e.data;
            else        last2 = e.data;
        end else begin
            chk($sformatf("rd_valid_idle L%0d", p), DW'(v), DW'(0));
            chk($sformatf("rd_data_hold L%0d", p), d, (p == 1) ? last1 : last2);
        end
    endtask

    // Monitor: compares outputs against the scoreboard every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("init_busy L1", DW'(busy1), DW'(init_left > 0));
                chk("init_busy L2", DW'(busy2), DW'(init_left > 0));
                port_chk(1, rvalid1, rdata1);
                port_chk(2, rvalid2, rdata2);
            end
        end
    end

    // Drive one cycle and advance the reference model at the edge.
    task automatic step(input logic r, input logic c, input logic w, input logic [AW-1:0] a_w,
                        input logic [DW-1:0] d, input logic [BW-1:0] b,
                        input logic rr, input logic [AW-1:0] a_r);
        exp_t e;
        @(negedge clk);
        rst = r; cs = c; we = w; wa = a_w; wd = d; be = b; re = rr; ra = a_r;
        @(posedge clk);
        #1;
        if (r) begin
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = INITV;
            sb1.delete();
            sb2.delete();
            last1   = '0;
            last2   = '0;
            started = 1'b1;
        end else if (init_left > 0) begin
            init_left--;
        end else if (c) begin
            if (w) mem_m[a_w] = apply_be(mem_m[a_w], d, b);
            if (rr) begin
                e.data = mem_m[a_r];
                e.due  = cyc + 1;
                sb1.push_back(e);
                e.due  = cyc + 2;
                sb2.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, 0, '0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, '0, '0, '0, 0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(0, 1, 0, '0, '0, '0, 1, a);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        step(0, 1, 1, a, d, b, 0, '0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; started = 1'b0; init_left = 0;
        last1 = '0; last2 = '0;
        rst = 1'b1; cs = 1'b0; we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0; be = '0;

        // Reset, full clear, then every word reads back as INIT_VALUE.
        do_reset();
        do_reset();
        idle(DEPTH);
        read_all();
        idle(3);

        // Random full-word writes, then back-to-back readback.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'($urandom), 2'b11);
        read_all();
        idle(3);

        // Mixed random traffic: partial byte enables, collisions, chip_select off.
        for (int i = 0; i < 300; i++)
            step(0, ($urandom_range(0, 7) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
                 BW'($urandom), 1'($urandom), AW'($urandom));
        idle(3);

        // Byte-enable merge on address 3 (expect 16'hAB34).
        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hABCD, 2'b10);
        rd(4'd3);
        // Collision forwarding on address 5 (expect 16'h00EF).
        wr(4'd5, 16'h0000, 2'b11);
        step(0, 1, 1, 4'd5, 16'hBEEF, 2'b01, 1, 4'd5);
        // chip_select low: no write, no read.
        step(0, 0, 1, 4'd7, 16'hFFFF, 2'b11, 1, 4'd7);
        rd(4'd7);
        idle(3);

        // Reset in the middle of INIT restarts the clear.
        do_reset();
        idle(8);
        do_reset();
        idle(DEPTH);
        read_all();
        idle(2);

        // Dirty the array, then reset with two reads in flight.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'($urandom), 2'b11);
        rd(4'd1);
        rd(4'd2);
        do_reset();
        idle(DEPTH);
        read_all();
        idle(4);

        chk("scoreboard_drained", DW'(sb1.size() + sb2.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
